// File: rtl/rt_seg_cnt_if.sv
// Bus bundle for rt_seg_cnt: control, load/compare values and count outputs.
// Snapshot signals exist only when RT_SEG_CNT_SNAPSHOT_EN is defined.
interface rt_seg_cnt_if #(
   parameter int CNT_W = 32
);
   logic             rt_i_clr;
   logic             rt_i_ld;
   logic [CNT_W-1:0] rt_i_ld_val;
   logic             rt_i_ce;
   logic             rt_i_dn;
   logic [CNT_W-1:0] rt_i_cmp;
   logic [CNT_W-1:0] rt_o_cnt;
   logic             rt_o_match;
   logic             rt_o_wrap;
`ifdef RT_SEG_CNT_SNAPSHOT_EN
   logic             rt_i_snap;
   logic [CNT_W-1:0] rt_o_snap_cnt;
   logic             rt_o_snap_vld;
`endif

   modport master (
`ifdef RT_SEG_CNT_SNAPSHOT_EN
      output rt_i_snap,
      input  rt_o_snap_cnt, rt_o_snap_vld,
`endif
      output rt_i_clr, rt_i_ld, rt_i_ld_val, rt_i_ce, rt_i_dn, rt_i_cmp,
      input  rt_o_cnt, rt_o_match, rt_o_wrap
   );

   modport slave (
`ifdef RT_SEG_CNT_SNAPSHOT_EN
      input  rt_i_snap,
      output rt_o_snap_cnt, rt_o_snap_vld,
`endif
      input  rt_i_clr, rt_i_ld, rt_i_ld_val, rt_i_ce, rt_i_dn, rt_i_cmp,
      output rt_o_cnt, rt_o_match, rt_o_wrap
   );
endinterface

// File: rtl/rt_seg_cnt.sv
// Segmented up/down counter with registered per-segment carry flags, compare and wrap/saturate.
// Optional snapshot capture is enabled by defining RT_SEG_CNT_SNAPSHOT_EN.
module rt_seg_cnt #(
   parameter int CNT_W = 32,
   parameter int SEG_W = 8,
   parameter int SAT   = 0
) (
   input  logic         rt_i_clk,
   input  logic         rt_i_rst_n,
   rt_seg_cnt_if.slave  bus
);
   localparam int N      = CNT_W / SEG_W;
   localparam bit SAT_EN = (SAT != 0);

   typedef logic [SEG_W-1:0] seg_t;

   seg_t [N-1:0] seg_q, seg_d;
   logic [N-1:0] ones_q, ones_d;
   logic [N-1:0] zeros_q, zeros_d;
   logic [N-1:0] eq_q, eq_d;
   logic [N-1:0] step_en;
   logic         wrap_q, wrap_d;
   logic         cnt_evt, at_limit, sat_hold;
   logic         pre_ones, pre_zeros, carry;

   // NOTE: every variable driven here gets a default first so no latch can be inferred.
   always_comb begin
      cnt_evt   = bus.rt_i_ce & ~bus.rt_i_clr & ~bus.rt_i_ld;
      at_limit  = bus.rt_i_dn ? (&zeros_q) : (&ones_q);
      wrap_d    = cnt_evt & at_limit;
      sat_hold  = SAT_EN & at_limit;
      pre_ones  = 1'b1;
      pre_zeros = 1'b1;
      carry     = 1'b0;
      step_en   = '0;
      seg_d     = seg_q;
      ones_d    = '0;
      zeros_d   = '0;
      eq_d      = '0;
      for (int k = 0; k < N; k++) begin
         // Carry into seg[k] is the AND of the registered flags of seg[0..k-1].
         carry      = bus.rt_i_dn ? pre_zeros : pre_ones;
         step_en[k] = cnt_evt & ~sat_hold & carry;
         pre_ones   = pre_ones & ones_q[k];
         pre_zeros  = pre_zeros & zeros_q[k];

         if (bus.rt_i_clr)
            seg_d[k] = '0;
         else if (bus.rt_i_ld)
            seg_d[k] = bus.rt_i_ld_val[k*SEG_W +: SEG_W];
         else if (step_en[k])
            seg_d[k] = bus.rt_i_dn ? (seg_q[k] - seg_t'(1)) : (seg_q[k] + seg_t'(1));

         ones_d[k]  = &seg_d[k];
         zeros_d[k] = ~|seg_d[k];
         eq_d[k]    = (seg_q[k] == bus.rt_i_cmp[k*SEG_W +: SEG_W]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
      if (!rt_i_rst_n) begin
         seg_q   <= '0;
         ones_q  <= '0;
         zeros_q <= '1;
         eq_q    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         ones_q  <= ones_d;
         zeros_q <= zeros_d;
         eq_q    <= eq_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.rt_o_cnt   = seg_q;
   assign bus.rt_o_match = &eq_q;
   assign bus.rt_o_wrap  = wrap_q;

`ifdef RT_SEG_CNT_SNAPSHOT_EN
   logic [CNT_W-1:0] snap_cnt_q;
   logic             snap_vld_q;

   // Captures the post-edge count so the snapshot is coherent across segments.
   always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
      if (!rt_i_rst_n) begin
         snap_cnt_q <= '0;
         snap_vld_q <= 1'b0;
      end else begin
         snap_vld_q <= bus.rt_i_snap;
         if (bus.rt_i_snap)
            snap_cnt_q <= seg_d;
      end
   end

   assign bus.rt_o_snap_cnt = snap_cnt_q;
   assign bus.rt_o_snap_vld = snap_vld_q;
`endif
endmodule

// File: tb/tb_rt_seg_cnt.sv
// Randomized self-checking bench for rt_seg_cnt: a 32/8 wrapping instance and a 16/4
// saturating instance share stimulus and are compared against an arithmetic reference model.
module tb_rt_seg_cnt;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rt_seg_cnt_if #(.CNT_W(32)) if0 ();
   rt_seg_cnt_if #(.CNT_W(16)) if1 ();

   rt_seg_cnt #(.CNT_W(32), .SEG_W(8), .SAT(0)) u_dut0 (
      .rt_i_clk   (clk),
      .rt_i_rst_n (rst_n),
      .bus        (if0.slave)
   );

   rt_seg_cnt #(.CNT_W(16), .SEG_W(4), .SAT(1)) u_dut1 (
      .rt_i_clk   (clk),
      .rt_i_rst_n (rst_n),
      .bus        (if1.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   longint unsigned m_cnt[2];
   longint unsigned m_lim[2];
   longint unsigned m_snap[2];
   bit              m_sat[2];
   bit              m_wrap[2];
   bit              m_match[2];
   bit              m_snap_vld[2];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("cnt0",   if0.rt_o_cnt,   m_cnt[0]);
      check("wrap0",  if0.rt_o_wrap,  m_wrap[0]);
      check("match0", if0.rt_o_match, m_match[0]);
      check("cnt1",   if1.rt_o_cnt,   m_cnt[1]);
      check("wrap1",  if1.rt_o_wrap,  m_wrap[1]);
      check("match1", if1.rt_o_match, m_match[1]);
`ifdef RT_SEG_CNT_SNAPSHOT_EN
      check("snap0",     if0.rt_o_snap_cnt, m_snap[0]);
      check("snap_vld0", if0.rt_o_snap_vld, m_snap_vld[0]);
      check("snap1",     if1.rt_o_snap_cnt, m_snap[1]);
      check("snap_vld1", if1.rt_o_snap_vld, m_snap_vld[1]);
`endif
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i]      = 0;
         m_wrap[i]     = 1'b0;
         m_match[i]    = 1'b0;
         m_snap[i]     = 0;
         m_snap_vld[i] = 1'b0;
      end
   endtask

   // One clock: drive, let the edge happen, advance the model, check 1 time unit later.
   task automatic cycle(input bit clr, input bit ld, input bit ce, input bit dn, input bit snap,
                        input logic [31:0] ldv, input logic [31:0] cmp);
      longint unsigned lv, cv;
      if0.rt_i_clr = clr;  if0.rt_i_ld = ld;  if0.rt_i_ce = ce;  if0.rt_i_dn = dn;
      if0.rt_i_ld_val = ldv;  if0.rt_i_cmp = cmp;
      if1.rt_i_clr = clr;  if1.rt_i_ld = ld;  if1.rt_i_ce = ce;  if1.rt_i_dn = dn;
      if1.rt_i_ld_val = ldv[15:0];  if1.rt_i_cmp = cmp[15:0];
`ifdef RT_SEG_CNT_SNAPSHOT_EN
      if0.rt_i_snap = snap;
      if1.rt_i_snap = snap;
`endif
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         lv = longint'(ldv) & m_lim[i];
         cv = longint'(cmp) & m_lim[i];
         m_match[i] = (m_cnt[i] == cv);
         m_wrap[i]  = 1'b0;
         if (clr)
            m_cnt[i] = 0;
         else if (ld)
            m_cnt[i] = lv;
         else if (ce && !dn) begin
            if (m_cnt[i] == m_lim[i]) begin
               m_wrap[i] = 1'b1;
               m_cnt[i]  = m_sat[i] ? m_lim[i] : 0;
            end else
               m_cnt[i] = m_cnt[i] + 1;
         end else if (ce && dn) begin
            if (m_cnt[i] == 0) begin
               m_wrap[i] = 1'b1;
               m_cnt[i]  = m_sat[i] ? 0 : m_lim[i];
            end else
               m_cnt[i] = m_cnt[i] - 1;
         end
         m_snap_vld[i] = snap;
         if (snap)
            m_snap[i] = m_cnt[i];
      end
      #1;
      check_all();
   endtask

   initial begin
      int          pulses;
      bit          dn_r;
      bit          r_clr, r_ld, r_ce, r_snap;
      logic [31:0] r_ldv, r_cmp;
      logic [31:0] seq_cnt[3];
      logic        seq_wrap[3];

      m_lim[0] = 64'hFFFF_FFFF;  m_sat[0] = 1'b0;
      m_lim[1] = 64'h0000_FFFF;  m_sat[1] = 1'b1;
      model_reset();

      // Reset state
      cycle_inputs_idle();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Free-running count up for 300 cycles
      for (int c = 0; c < 300; c++)
         cycle(0, 0, 1, 0, 0, '0, 32'hDEAD_BEEF);
      check("cnt300", if0.rt_o_cnt, 64'd300);

      // Wrap through 0xFFFFFFFF on the wrapping instance
      cycle(0, 1, 0, 0, 0, 32'hFFFF_FFFE, '1);
      seq_cnt  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      seq_wrap = '{1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 3; c++) begin
         cycle(0, 0, 1, 0, 0, '0, '1);
         check($sformatf("wrapseq_cnt%0d", c), if0.rt_o_cnt, seq_cnt[c]);
         check($sformatf("wrapseq_wrap%0d", c), if0.rt_o_wrap, seq_wrap[c]);
      end

      // Attempted underflow on the saturating instance
      cycle(0, 1, 0, 1, 0, 32'h0000_0001, '1);
      seq_wrap = '{1'b0, 1'b1, 1'b1};
      for (int c = 0; c < 3; c++) begin
         cycle(0, 0, 1, 1, 0, '0, '1);
         check($sformatf("satdn_cnt%0d", c), if1.rt_o_cnt, 64'd0);
         check($sformatf("satdn_wrap%0d", c), if1.rt_o_wrap, seq_wrap[c]);
      end

      // Compare pulse at 0x100 while counting up from 0xF0
      cycle(0, 1, 0, 0, 0, 32'h0000_00F0, 32'h0000_0100);
      pulses = 0;
      for (int c = 0; c < 24; c++) begin
         cycle(0, 0, 1, 0, 0, '0, 32'h0000_0100);
         if (if0.rt_o_match) begin
            pulses++;
            check("match_at", if0.rt_o_cnt, 64'h101);
         end
      end
      check("match_pulses", pulses, 64'd1);

      // clr beats ld beats ce; neither raises wrap
      cycle(0, 1, 0, 0, 0, 32'h0000_0055, '0);
      cycle(1, 1, 1, 0, 0, 32'h1234_5678, '0);
      check("clr_prio_cnt", if0.rt_o_cnt, 64'd0);
      check("clr_prio_wrap", if0.rt_o_wrap, 64'd0);
      cycle(0, 1, 1, 0, 0, 32'hFFFF_FFFF, '0);
      check("ld_prio_cnt", if0.rt_o_cnt, 64'hFFFF_FFFF);
      check("ld_prio_wrap", if0.rt_o_wrap, 64'd0);

`ifdef RT_SEG_CNT_SNAPSHOT_EN
      cycle(0, 1, 0, 0, 0, 32'h00FF_FFFF, '0);
      cycle(0, 0, 1, 0, 1, '0, '0);
      check("snap_carry", if0.rt_o_snap_cnt, 64'h0100_0000);
      cycle(0, 0, 0, 0, 0, '0, '0);
      check("snap_vld_drop", if0.rt_o_snap_vld, 64'd0);
`endif

      // Randomized traffic
      dn_r = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         r_clr  = ($urandom_range(0, 31) == 0);
         r_ld   = ($urandom_range(0, 9) == 0);
         r_ce   = ($urandom_range(0, 3) != 0);
         r_snap = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0)
            dn_r = ~dn_r;
         case ($urandom_range(0, 5))
            0:       r_ldv = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            1:       r_ldv = 32'($urandom_range(0, 3));
            2:       r_ldv = 32'h0000_FFFF - 32'($urandom_range(0, 2));
            3:       r_ldv = 32'h00FF_FFFE;
            4:       r_ldv = 32'h0001_0001;
            default: r_ldv = $urandom;
         endcase
         if ($urandom_range(0, 1) == 1)
            r_cmp = 32'(m_cnt[0]) + 32'($urandom_range(0, 3));
         else
            r_cmp = $urandom;
         cycle(r_clr, r_ld, r_ce, dn_r, r_snap, r_ldv, r_cmp);
      end

      // Asynchronous reset in the middle of counting
      cycle(0, 1, 0, 0, 1, 32'h0000_FFFF, '0);
      cycle(0, 0, 1, 0, 1, '0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check("async_rst_cnt", if0.rt_o_cnt, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++)
         cycle(0, 0, 1, 0, 0, '0, '0);
      check("post_rst_cnt", if0.rt_o_cnt, 64'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   task automatic cycle_inputs_idle();
      if0.rt_i_clr = 1'b0;  if0.rt_i_ld = 1'b0;  if0.rt_i_ce = 1'b0;  if0.rt_i_dn = 1'b0;
      if0.rt_i_ld_val = '0;  if0.rt_i_cmp = '0;
      if1.rt_i_clr = 1'b0;  if1.rt_i_ld = 1'b0;  if1.rt_i_ce = 1'b0;  if1.rt_i_dn = 1'b0;
      if1.rt_i_ld_val = '0;  if1.rt_i_cmp = '0;
`ifdef RT_SEG_CNT_SNAPSHOT_EN
      if0.rt_i_snap = 1'b0;
      if1.rt_i_snap = 1'b0;
`endif
   endtask
endmodule

// File: doc/rt_seg_cnt.md
# rt_seg_cnt

Parametrised segmented up/down counter. It is the general successor to the fixed 32-bit, four-byte counter: width, segment size, direction, load, compare and wrap/saturate behaviour are all selectable. Segments carry through registered "all-ones" or "all-zeros" terms, so the carry chain never exceeds one segment's adder. It sits in timing and event-count paths wherever a wide free-running or reloadable count is needed at full clock rate.

## Interface
Parameters:
- `CNT_W`, 32, total counter width. Must be an integer multiple of `SEG_W`; legal range 8..128.
- `SEG_W`, 8, segment width. Legal range 4..16.
- `SAT`, 0, overflow mode. 0 = wrap modulo 2^CNT_W; 1 = saturate at the limit.

Ports:
- `rt_i_clk`, input, 1, the single clock. Everything is rising-edge.
- `rt_i_rst_n`, input, 1, asynchronous active-low reset.
- `rt_i_clr`, input, 1, synchronous clear to 0.
- `rt_i_ld`, input, 1, synchronous load of `rt_i_ld_val`.
- `rt_i_ld_val`, input, CNT_W, load value.
- `rt_i_ce`, input, 1, count enable.
- `rt_i_dn`, input, 1, direction. 0 = up, 1 = down.
- `rt_i_cmp`, input, CNT_W, compare value.
- `rt_o_cnt`, output, CNT_W, registered count.
- `rt_o_match`, output, 1, registered compare flag.
- `rt_o_wrap`, output, 1, one-cycle overflow/underflow pulse.
- `rt_i_snap` (only with the macro defined), input, 1, snapshot request.
- `rt_o_snap_cnt` (only with the macro defined), output, CNT_W, snapshot value.
- `rt_o_snap_vld` (only with the macro defined), output, 1, snapshot valid.

## Operation
- The counter holds N = CNT_W/SEG_W segments, seg[0] least significant. `rt_o_cnt` = {seg[N-1], ..., seg[0]}.
- Priority per edge: clr > ld > ce. When clr, ld and ce are all low, the count holds.
- Up count: seg[k] increments when ce=1 and seg[0..k-1] are all ones.
- Down count: seg[k] decrements when ce=1 and seg[0..k-1] are all zeros.
- Each segment keeps two registered flags, "all ones" and "all zeros", computed from its next value. The carry enable for seg[k] is therefore an AND of k flag bits. The segment adders are not chained combinationally.
- Wrap point, up direction: count = 2^CNT_W-1 with ce=1, dn=0.
  - SAT=0: next count = 0.
  - SAT=1: count holds at 2^CNT_W-1.
  - In both modes `rt_o_wrap` pulses.
- Wrap point, down direction: count = 0 with ce=1, dn=1.
  - SAT=0: next count = 2^CNT_W-1.
  - SAT=1: count holds at 0.
  - In both modes `rt_o_wrap` pulses.
- clr or ld never raises `rt_o_wrap`, even when ce is high in the same cycle.
- `rt_o_match` = 1 in the cycle after `rt_o_cnt` == `rt_i_cmp` was true. The comparison is made segment-wise, with the per-segment equal bits registered and then ANDed.
- A change of `rt_i_dn` takes effect on the next ce edge. There is no extra state.

## Timing
- Reset (`rt_i_rst_n` low) acts asynchronously:
  - `rt_o_cnt` = 0 and `rt_o_wrap` = 0.
  - `rt_o_match` = 0 (it then evaluates normally from the first clock).
  - `rt_o_snap_cnt` = 0 and `rt_o_snap_vld` = 0.
  - Segment flags: all-zeros = 1, all-ones = 0.
- Release of reset is synchronised by the integrator. The first count occurs on the first rising edge with reset high and ce=1.
- clr, ld and count take effect on the edge where they are sampled. The new value is visible on `rt_o_cnt` immediately after that edge (latency 1).
- `rt_o_wrap` is registered. It is high for exactly the one cycle following the wrap edge.
- `rt_o_match` has a latency of 1 cycle relative to `rt_o_cnt`.
- Reset in the middle of a count aborts the operation. No partial segment update is permitted.
- Throughput: one count per clock at any CNT_W. The critical path is one SEG_W adder plus an N-input AND.

## Configuration
- Macro: `RT_SEG_CNT_SNAPSHOT_EN`.
- Defined: adds `rt_i_snap`, `rt_o_snap_cnt` and `rt_o_snap_vld`.
  - `rt_i_snap`=1 captures the full post-edge count into `rt_o_snap_cnt` on the same edge as that count update. The capture is coherent across all segments.
  - `rt_o_snap_vld` is high for one cycle after each capture.
  - Back-to-back snap requests capture on every cycle.
  - clr or ld on the snap edge: the snapshot captures the cleared or loaded value.
- Undefined: the snapshot ports and logic are absent. The remaining behaviour is identical.

## Test plan
All scenarios use CNT_W=32, SEG_W=8 unless noted.
- Reset, then ce=1 for 300 cycles, dn=0 -> `rt_o_cnt`=300 (0x12C). seg[1] increments exactly once, at 255->256.
- ld 0xFFFFFFFE, then ce=1 for 3 cycles with SAT=0 -> count goes 0xFFFFFFFF, 0x00000000, 0x00000001. `rt_o_wrap` is high for one cycle only, immediately after the 0xFFFFFFFF->0 edge.
- SAT=1, dn=1, ld 0x00000001, then ce for 3 cycles -> count goes 0, 0, 0. `rt_o_wrap` pulses in each of the two cycles following an attempted underflow.
- cmp=0x00000100, count up from 0xF0 -> `rt_o_match` is high for exactly one cycle, one cycle after `rt_o_cnt`=0x100.
- clr=1, ld=1 and ce=1 in the same cycle, count at 0x55 -> count = 0 and no wrap. Then ld=1, ce=1 with ld_val 0xFFFFFFFF -> count = 0xFFFFFFFF and no wrap.
- `RT_SEG_CNT_SNAPSHOT_EN` defined, CNT_W=64, SEG_W=16: ld 0x0000FFFFFFFFFFFF, then ce with snap on the same edge -> snap = 0x0001000000000000, `rt_o_snap_vld` is high for 1 cycle. Asserting `rt_i_rst_n` low mid-count clears the count and snapshot asynchronously.
